// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, the default base address and the word shift.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int unsigned WORD_SHIFT    = 2;

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port synchronous word array with a registered read port.
// Ports: clk, rst (sync, clears all words), we/re, idx, wdata -> rdata.
module dmem_sram_array #(
  parameter int DATA_LEN         = 32,
  parameter int MEM_ADDRESS_LINE = 64,
  parameter int IDX_W            = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] rdata
);

  logic [DATA_LEN-1:0] mem [MEM_ADDRESS_LINE];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_ADDRESS_LINE; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[idx] <= wdata;
      end
      if (re) begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the MA-stage load/store port: one word per handshake,
// programmable wait states, single-cycle resp_valid pulse with rdata/err.
module dmem_responder
  import arm_mem_pkg::*;
#(
  parameter int DATA_LEN         = 32,
  parameter int ADDRESS_LEN      = 32,
  parameter int MEM_ADDRESS_LINE = 64,
  parameter int WAIT_CYCLES      = 3,
  parameter int BASE_ADDR        = BASE_ADDR_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   req_we,
  input  logic [ADDRESS_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0]    req_wdata,
  output logic                   req_ready,
  output logic                   resp_valid,
  output logic [DATA_LEN-1:0]    resp_rdata,
  output logic                   resp_err
);

  localparam int CNT_W =
    (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int IDX_W =
    (MEM_ADDRESS_LINE > 1) ? $clog2(MEM_ADDRESS_LINE) : 1;
  localparam int CNT_INIT =
    (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  localparam logic [ADDRESS_LEN-1:0] BASE =
    ADDRESS_LEN'(BASE_ADDR);
  localparam logic [ADDRESS_LEN-1:0] LINES =
    ADDRESS_LEN'(MEM_ADDRESS_LINE);

  state_t state, nstate;
  logic [CNT_W-1:0] cnt;

  logic                   we_q;
  logic [ADDRESS_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0]    wdata_q;

  logic                   cur_we;
  logic [ADDRESS_LEN-1:0] cur_addr;
  logic [DATA_LEN-1:0]    cur_wdata;
  logic [ADDRESS_LEN-1:0] off;
  logic [ADDRESS_LEN-1:0] word;
  logic                   fault;
  logic                   accept;
  logic                   enter_resp;
  logic                   arr_we;
  logic                   arr_re;
  logic                   rd_sel;
  logic [DATA_LEN-1:0]    arr_rdata;

  assign accept = req_valid && (state == IDLE);

  // With zero wait states RESP is entered on the accept edge itself,
  // before the capture registers hold the request, so decode the live
  // inputs while idle and the captured copy otherwise.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
  end

  assign off   = cur_addr - BASE;
  assign word  = off >> WORD_SHIFT;
  assign fault = (cur_addr < BASE)
               | (word >= LINES)
               | (cur_addr[1:0] != 2'b00);

  assign enter_resp = (nstate == RESP) && (state != RESP);
  assign arr_we     = enter_resp && cur_we && !fault;
  assign arr_re     = enter_resp && !cur_we && !fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          nstate = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          nstate = RESP;
        end
      end
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        cnt     <= CNT_W'(CNT_INIT);
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // The array read register only moves on a good load, so the
  // returned word is held until the next RESP entry; rd_sel zeroes
  // it for stores and faults.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sel   <= 1'b0;
      resp_err <= 1'b0;
    end else if (enter_resp) begin
      rd_sel   <= !cur_we && !fault;
      resp_err <= fault;
    end
  end

  assign resp_rdata = rd_sel ? arr_rdata : '0;

  dmem_sram_array #(
    .DATA_LEN        (DATA_LEN),
    .MEM_ADDRESS_LINE(MEM_ADDRESS_LINE),
    .IDX_W           (IDX_W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .re   (arr_re),
    .idx  (word[IDX_W-1:0]),
    .wdata(cur_wdata),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (3 and 0 wait states),
// directed cases plus random traffic against a transaction-level model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst = 2'b11;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_we = '0;
  logic [1:0][31:0] req_addr = '0;
  logic [1:0][31:0] req_wdata = '0;
  logic [1:0]       req_ready;
  logic [1:0]       resp_valid;
  logic [1:0][31:0] resp_rdata;
  logic [1:0]       resp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    if (a < 32'd1024) return 1'b1;
    if (a % 4 != 0) return 1'b1;
    if ((a - 32'd1024) / 4 >= 64) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - 32'd1024) / 4);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int WC = (g == 0) ? 3 : 0;

    dmem_responder #(.WAIT_CYCLES(WC)) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_ready (req_ready[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );

    // Transaction model: a request accepted at edge A completes on
    // edge A+WC (the edge entering the response cycle), and the next
    // request can be taken no earlier than two edges after that.
    logic [31:0] mem [64];
    bit          started = 0;
    bit          pend = 0;
    int          mc = 0;
    int          acc = 0;
    int          last_resp = -10;
    bit          p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wd;
    logic [31:0] exp_rd = '0;
    bit          exp_err = 0;

    always @(posedge clk) begin
      mc++;
      if (rst[g]) begin
        started   = 1;
        pend      = 0;
        last_resp = -10;
        exp_rd    = '0;
        exp_err   = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
      end else if (started) begin
        if (!pend && mc >= last_resp + 2 && req_valid[g] === 1'b1) begin
          pend   = 1;
          acc    = mc;
          p_we   = req_we[g];
          p_addr = req_addr[g];
          p_wd   = req_wdata[g];
        end
        if (pend && mc == acc + WC) begin
          pend      = 0;
          last_resp = mc;
          if (bad_addr(p_addr)) begin
            exp_rd  = '0;
            exp_err = 1;
          end else if (p_we) begin
            mem[word_of(p_addr)] = p_wd;
            exp_rd  = '0;
            exp_err = 0;
          end else begin
            exp_rd  = mem[word_of(p_addr)];
            exp_err = 0;
          end
        end
      end
    end

    always @(negedge clk) begin
      if (started && !rst[g]) begin
        chk($sformatf("w%0d_resp_valid", WC),
            32'(resp_valid[g]), 32'(last_resp == mc));
        chk($sformatf("w%0d_req_ready", WC),
            32'(req_ready[g]), 32'(!pend && last_resp != mc));
        chk($sformatf("w%0d_resp_rdata", WC),
            resp_rdata[g], exp_rd);
        chk($sformatf("w%0d_resp_err", WC),
            32'(resp_err[g]), 32'(exp_err));
      end
    end
  end

  // All tasks start and end 2 time units after a rising edge.
  task automatic do_req(input int g, input bit we,
                        input logic [31:0] a, input logic [31:0] d,
                        output int acc);
    bit r;
    int n;
    n = 0;
    acc = -1;
    req_we[g] = we;
    req_addr[g] = a;
    req_wdata[g] = d;
    req_valid[g] = 1'b1;
    while (acc < 0 && n < 40) begin
      r = req_ready[g];
      @(posedge clk);
      #2;
      if (r) acc = cyc;
      n++;
    end
    req_valid[g] = 1'b0;
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_resp(input int g, output logic [31:0] rd,
                           output logic err, output int rc);
    int n;
    n = 0;
    rc = -1;
    rd = '0;
    err = 1'b0;
    while (rc < 0 && n < 40) begin
      @(negedge clk);
      if (resp_valid[g]) begin
        rc = cyc;
        rd = resp_rdata[g];
        err = resp_err[g];
      end
      n++;
    end
    @(posedge clk);
    #2;
    if (rc < 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  // lat = consumer edge that samples resp_valid minus the accept edge
  task automatic txn(input int g, input bit we,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err,
                     output int lat);
    int acc;
    int rc;
    lat = -1;
    rd = '0;
    err = 1'b0;
    do_req(g, we, a, d, acc);
    if (acc >= 0) begin
      wait_resp(g, rd, err, rc);
      if (rc >= 0) lat = rc + 1 - acc;
    end
  endtask

  task automatic reset_dut(input int g);
    rst[g] = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst[g] = 1'b0;
  endtask

  task automatic count_resp(input int g, input int ncyc,
                            output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (resp_valid[g]) cnt++;
    end
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'd1024 + 4 * $urandom_range(0, 63);
      1:       return 32'd1024 + 4 * $urandom_range(0, 7);
      2:       return 32'($urandom_range(1000, 1300));
      default: return 32'd1024 + 4 * $urandom_range(60, 66);
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          n;
    int          acc;

    @(posedge clk);
    #2;
    reset_dut(0);
    reset_dut(1);

    @(negedge clk);
    chk("rst_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst_rdata", resp_rdata[0], 32'd0);
    @(posedge clk);
    #2;

    txn(0, 0, 32'd1024, 32'd0, rd, err, lat);
    chk("rst_load_1024", rd, 32'd0);

    txn(0, 1, 32'd1028, 32'hDEADBEEF, rd, err, lat);
    chk("w3_store_lat", 32'(lat), 32'd4);
    chk("w3_store_err", 32'(err), 32'd0);
    txn(0, 0, 32'd1028, 32'd0, rd, err, lat);
    chk("w3_load_lat", 32'(lat), 32'd4);
    chk("w3_load_data", rd, 32'hDEADBEEF);
    chk("w3_load_err", 32'(err), 32'd0);
    chk("model_pin_rd", gi[0].exp_rd, 32'hDEADBEEF);

    txn(0, 1, 32'd1276, 32'h0000A5A5, rd, err, lat);
    chk("top_store_err", 32'(err), 32'd0);
    txn(0, 0, 32'd1276, 32'd0, rd, err, lat);
    chk("top_load_data", rd, 32'h0000A5A5);
    txn(0, 0, 32'd1280, 32'd0, rd, err, lat);
    chk("over_err", 32'(err), 32'd1);
    chk("over_rdata", rd, 32'd0);
    chk("model_pin_err", 32'(gi[0].exp_err), 32'd1);
    txn(0, 0, 32'd1020, 32'd0, rd, err, lat);
    chk("below_err", 32'(err), 32'd1);
    txn(0, 0, 32'd1026, 32'd0, rd, err, lat);
    chk("misalign_err", 32'(err), 32'd1);
    txn(0, 1, 32'd1278, 32'h00001111, rd, err, lat);
    chk("bad_store_err", 32'(err), 32'd1);
    txn(0, 0, 32'd1276, 32'd0, rd, err, lat);
    chk("bad_store_kept", rd, 32'h0000A5A5);

    do_req(0, 1, 32'd1032, 32'h12345678, acc);
    @(posedge clk);
    #2;
    rst[0] = 1'b1;
    @(posedge clk);
    #2;
    rst[0] = 1'b0;
    count_resp(0, 6, n);
    chk("abort_no_resp", 32'(n), 32'd0);
    txn(0, 0, 32'd1032, 32'd0, rd, err, lat);
    chk("abort_load", rd, 32'd0);

    do_req(0, 1, 32'd1036, 32'h00000055, acc);
    req_valid[0] = 1'b1;
    req_we[0] = 1'b1;
    req_addr[0] = 32'd1040;
    req_wdata[0] = 32'h00000099;
    @(posedge clk);
    #2;
    req_valid[0] = 1'b0;
    wait_resp(0, rd, err, n);
    chk("ignore_first_err", 32'(err), 32'd0);
    count_resp(0, 6, n);
    chk("ignore_no_second", 32'(n), 32'd0);
    txn(0, 0, 32'd1040, 32'd0, rd, err, lat);
    chk("ignore_untouched", rd, 32'd0);
    txn(0, 0, 32'd1036, 32'd0, rd, err, lat);
    chk("ignore_first_data", rd, 32'h00000055);

    txn(1, 1, 32'd1024, 32'h00000077, rd, err, lat);
    chk("w0_store_lat", 32'(lat), 32'd1);
    txn(1, 0, 32'd1024, 32'd0, rd, err, lat);
    chk("w0_load_lat", 32'(lat), 32'd1);
    chk("w0_load_data", rd, 32'h00000077);
    req_we[1] = 1'b0;
    req_addr[1] = 32'd1024;
    req_valid[1] = 1'b1;
    count_resp(1, 8, n);
    req_valid[1] = 1'b0;
    chk("w0_b2b_count", 32'(n), 32'd4);

    for (int g = 0; g < 2; g++) begin
      repeat (500) begin
        req_valid[g] = ($urandom_range(0, 2) == 0);
        req_we[g] = 1'($urandom_range(0, 1));
        req_addr[g] = rand_addr();
        req_wdata[g] = $urandom;
        rst[g] = ($urandom_range(0, 79) == 0);
        @(posedge clk);
        #2;
      end
      rst[g] = 1'b0;
      req_valid[g] = 1'b0;
      repeat (6) @(posedge clk);
      #2;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
